cb_exec_unit: RTL and testbench

- Parametrised sequential executor for the Z80 CB-prefix group: rotates/shifts (RLC, RRC, RL, RR, SLA, SRA, SLL, SRL), BIT, RES and SET.
- Register operands are taken from a port. The (HL) operand is handled with a read-modify-write through its own memory handshake.
- Sits beside the tv80-derived core as an offloaded CB datapath. The same bench infrastructure exercises it with register and (HL) vectors.

---
 rtl/cb_exec_unit.sv | 188 ++++++++++++++++++
 tb/tb_cb_exec_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cb_exec_unit.sv
// Sequential executor for the Z80 CB-prefix group (rotate/shift, BIT, RES, SET) with (HL) read-modify-write.
// Optional build macro CB_EXEC_SLL_EN enables SLL (opcodes 0x30-0x37); otherwise those opcodes complete as illegal no-ops.
module cb_exec_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] operand,
    input  logic [7:0]        f_in,
    input  logic [ADDR_W-1:0] hl,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        f_out,
    output logic              illegal
);

    typedef enum logic [2:0] {IDLE, RD, EXEC, WR, DONE} state_t;

    state_t state, next_state;

    logic [7:0]        op_q;
    logic [DATA_W-1:0] opnd_q;
    logic [7:0]        f_q;
    logic [ADDR_W-1:0] hl_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        fnew_q;
    logic [DATA_W-1:0] res_q;
    logic [7:0]        fout_q;

    logic              hl_form;
    logic              is_bit;
    logic              undef_op;
    logic              needs_wr;
    logic [2:0]        bit_n;
    logic [DATA_W-1:0] bit_mask;
    logic [DATA_W-1:0] shift_r;
    logic              shift_c;
    logic [DATA_W-1:0] exec_res;
    logic [7:0]        exec_f;

    assign hl_form  = (op_q[2:0] == 3'd6);
    assign is_bit   = (op_q[7:6] == 2'b01);
    assign bit_n    = op_q[5:3];
    assign bit_mask = DATA_W'(1) << bit_n;

`ifdef CB_EXEC_SLL_EN
    assign undef_op = 1'b0;
`else
    assign undef_op = (op_q[7:3] == 5'b00110);
`endif

    // BIT and undefined ops leave memory untouched, so (HL) forms skip the write.
    assign needs_wr = hl_form && !is_bit && !undef_op;

    always_comb begin
        shift_r = opnd_q;
        shift_c = 1'b0;
        case (op_q[5:3])
            3'd0: begin shift_r = {opnd_q[DATA_W-2:0], opnd_q[DATA_W-1]}; shift_c = opnd_q[DATA_W-1]; end
            3'd1: begin shift_r = {opnd_q[0], opnd_q[DATA_W-1:1]};        shift_c = opnd_q[0];        end
            3'd2: begin shift_r = {opnd_q[DATA_W-2:0], f_q[0]};           shift_c = opnd_q[DATA_W-1]; end
            3'd3: begin shift_r = {f_q[0], opnd_q[DATA_W-1:1]};           shift_c = opnd_q[0];        end
            3'd4: begin shift_r = {opnd_q[DATA_W-2:0], 1'b0};             shift_c = opnd_q[DATA_W-1]; end
            3'd5: begin shift_r = {opnd_q[DATA_W-1], opnd_q[DATA_W-1:1]}; shift_c = opnd_q[0];        end
            3'd6: begin shift_r = {opnd_q[DATA_W-2:0], 1'b1};             shift_c = opnd_q[DATA_W-1]; end
            default: begin shift_r = {1'b0, opnd_q[DATA_W-1:1]};          shift_c = opnd_q[0];        end
        endcase
    end

    // Flag byte layout: S Z Y H X PV N C.
    always_comb begin
        exec_res = opnd_q;
        exec_f   = f_q;
        case (op_q[7:6])
            2'b00: begin
                if (!undef_op) begin
                    exec_res = shift_r;
                    exec_f   = {shift_r[DATA_W-1], (shift_r == '0), shift_r[5], 1'b0,
                                shift_r[3], ~^shift_r[7:0], 1'b0, shift_c};
                end
            end
            2'b01: begin
                exec_f = {(bit_n == 3'd7) & opnd_q[7], ~opnd_q[bit_n], opnd_q[5], 1'b1,
                          opnd_q[3], ~opnd_q[bit_n], 1'b0, f_q[0]};
            end
            2'b10:   exec_res = opnd_q & ~bit_mask;
            default: exec_res = opnd_q | bit_mask;
        endcase
    end

    always_comb begin
        next_state = state;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = (opcode[2:0] == 3'd6) ? RD : EXEC;
            end
            RD: begin
                mem_rd   = 1'b1;
                mem_addr = hl_q;
                busy     = 1'b1;
                if (mem_ack) next_state = EXEC;
            end
            EXEC: begin
                busy       = 1'b1;
                next_state = needs_wr ? WR : DONE;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_addr  = hl_q;
                mem_wdata = wdata_q;
                busy      = 1'b1;
                if (mem_ack) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                illegal    = undef_op;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // result/f_out only change on the edge that enters DONE, so they stay stable between done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= '0;
            opnd_q  <= '0;
            f_q     <= '0;
            hl_q    <= '0;
            wdata_q <= '0;
            fnew_q  <= '0;
            res_q   <= '0;
            fout_q  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q   <= opcode;
                        opnd_q <= operand;
                        f_q    <= f_in;
                        hl_q   <= hl;
                    end
                end
                RD: begin
                    if (mem_ack) opnd_q <= mem_rdata;
                end
                EXEC: begin
                    wdata_q <= exec_res;
                    fnew_q  <= exec_f;
                    if (next_state == DONE) begin
                        res_q  <= exec_res;
                        fout_q <= exec_f;
                    end
                end
                WR: begin
                    if (mem_ack) begin
                        res_q  <= wdata_q;
                        fout_q <= fnew_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;
    assign f_out  = fout_q;

endmodule

// File: tb/tb_cb_exec_unit.sv
// Directed bench for cb_exec_unit: register and (HL) vectors with hand-computed results, plus reset abort.
// A small memory responder inside run_op acknowledges reads/writes after a chosen delay.
module tb_cb_exec_unit;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        opcode;
    logic [DATA_W-1:0] operand;
    logic [7:0]        f_in;
    logic [ADDR_W-1:0] hl;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [7:0]        f_out;
    logic              illegal;

    int n_checks = 0;
    int n_errors = 0;

    int          obs_cycles;
    int          obs_rd;
    int          obs_wr;
    logic [15:0] obs_rd_addr;
    logic [15:0] obs_wr_addr;
    logic [7:0]  obs_wdata;
    logic        obs_overlap;
    logic [7:0]  obs_res;
    logic [7:0]  obs_f;
    logic        obs_ill;

    cb_exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .operand(operand),
        .f_in(f_in), .hl(hl), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy),
        .done(done), .result(result), .f_out(f_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Starts one op and plays memory until done; inputs are scrambled after acceptance.
    task automatic run_op(input logic [7:0] opc, input logic [7:0] opnd, input logic [7:0] fin,
                          input logic [15:0] addr, input logic [7:0] rdata,
                          input int rd_dly, input int wr_dly);
        int rd_wait = 0;
        int wr_wait = 0;
        bit seen = 0;
        obs_cycles = 0; obs_rd = 0; obs_wr = 0; obs_overlap = 0;
        obs_rd_addr = '0; obs_wr_addr = '0; obs_wdata = '0;
        obs_res = '0; obs_f = '0; obs_ill = 0;
        @(negedge clk);
        start = 1'b1; opcode = opc; operand = opnd; f_in = fin; hl = addr; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0; opcode = 8'h00; operand = ~opnd; f_in = ~fin; hl = ~addr;
        for (int cyc = 1; cyc <= 50 && !seen; cyc++) begin
            mem_ack   = 1'b0;
            mem_rdata = ~rdata;
            if (mem_rd && mem_wr) obs_overlap = 1'b1;
            if (done) begin
                seen = 1;
                obs_cycles = cyc; obs_res = result; obs_f = f_out; obs_ill = illegal;
            end else begin
                if (mem_rd) begin
                    obs_rd++; obs_rd_addr = mem_addr; rd_wait++;
                    if (rd_wait > rd_dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
                end
                if (mem_wr) begin
                    obs_wr++; obs_wr_addr = mem_addr; obs_wdata = mem_wdata; wr_wait++;
                    if (wr_wait > wr_dly) mem_ack = 1'b1;
                end
                @(negedge clk);
            end
        end
        mem_ack = 1'b0;
        check("done_seen", 32'(seen), 1);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
    endtask

    task automatic vec_reg(input string tag, input logic [7:0] opc, input logic [7:0] opnd,
                           input logic [7:0] fin, input logic [7:0] exp_res,
                           input logic [7:0] exp_f, input logic exp_ill);
        run_op(opc, opnd, fin, 16'hA5A5, 8'h00, 0, 0);
        check({tag, "_lat"}, obs_cycles, 2);
        check({tag, "_res"}, 32'(obs_res), 32'(exp_res));
        check({tag, "_f"}, 32'(obs_f), 32'(exp_f));
        check({tag, "_ill"}, 32'(obs_ill), 32'(exp_ill));
        check({tag, "_nomem"}, obs_rd + obs_wr, 0);
    endtask

    task automatic vec_hl(input string tag, input logic [7:0] opc, input logic [7:0] fin,
                          input logic [15:0] addr, input logic [7:0] rdata,
                          input int rd_dly, input int wr_dly, input logic exp_write,
                          input logic [7:0] exp_res, input logic [7:0] exp_f, input logic exp_ill);
        int exp_lat;
        run_op(opc, 8'hFF, fin, addr, rdata, rd_dly, wr_dly);
        exp_lat = 3 + rd_dly + (exp_write ? wr_dly + 1 : 0);
        check({tag, "_lat"}, obs_cycles, exp_lat);
        check({tag, "_nrd"}, obs_rd, rd_dly + 1);
        check({tag, "_rdaddr"}, 32'(obs_rd_addr), 32'(addr));
        check({tag, "_nwr"}, obs_wr, exp_write ? wr_dly + 1 : 0);
        if (exp_write) begin
            check({tag, "_wraddr"}, 32'(obs_wr_addr), 32'(addr));
            check({tag, "_wdata"}, 32'(obs_wdata), 32'(exp_res));
        end
        check({tag, "_overlap"}, 32'(obs_overlap), 0);
        check({tag, "_res"}, 32'(obs_res), 32'(exp_res));
        check({tag, "_f"}, 32'(obs_f), 32'(exp_f));
        check({tag, "_ill"}, 32'(obs_ill), 32'(exp_ill));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; opcode = '0; operand = '0; f_in = '0; hl = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rd", 32'(mem_rd), 0);
        check("rst_wr", 32'(mem_wr), 0);
        check("rst_addr", 32'(mem_addr), 0);
        check("rst_wdata", 32'(mem_wdata), 0);
        check("rst_res", 32'(result), 0);
        check("rst_f", 32'(f_out), 0);
        check("rst_ill", 32'(illegal), 0);
        check("rst_state", 32'(dut.state), 0);
        reset = 1'b0;

        vec_reg("sla_a",   8'h27, 8'hBF, 8'h00, 8'h7E, 8'h2D, 1'b0);
        vec_reg("rlc_b",   8'h00, 8'h81, 8'h00, 8'h03, 8'h05, 1'b0);
        vec_reg("rrc_b",   8'h08, 8'h01, 8'h00, 8'h80, 8'h81, 1'b0);
        vec_reg("rl_b",    8'h10, 8'h80, 8'h01, 8'h01, 8'h01, 1'b0);
        vec_reg("rr_b",    8'h18, 8'h01, 8'h00, 8'h00, 8'h45, 1'b0);
        vec_reg("sra_b",   8'h28, 8'h81, 8'h00, 8'hC0, 8'h85, 1'b0);
        vec_reg("srl_b",   8'h38, 8'h81, 8'h00, 8'h40, 8'h01, 1'b0);
        vec_reg("bit7_a",  8'h7F, 8'h80, 8'h01, 8'h80, 8'h91, 1'b0);
        vec_reg("bit3_a",  8'h5F, 8'h08, 8'h00, 8'h08, 8'h18, 1'b0);
        vec_reg("bit0_b",  8'h40, 8'hFE, 8'hFF, 8'hFE, 8'h7D, 1'b0);
        vec_reg("res1_a",  8'h8F, 8'hFF, 8'hA5, 8'hFD, 8'hA5, 1'b0);
        vec_reg("set0_a",  8'hC7, 8'h00, 8'h3C, 8'h01, 8'h3C, 1'b0);
        vec_reg("set7_b",  8'hF8, 8'h00, 8'h00, 8'h80, 8'h00, 1'b0);
`ifdef CB_EXEC_SLL_EN
        vec_reg("sll_a",   8'h37, 8'h01, 8'h00, 8'h03, 8'h04, 1'b0);
`else
        vec_reg("sll_a",   8'h37, 8'h01, 8'h00, 8'h01, 8'h00, 1'b1);
`endif

        vec_hl("sla_hl",  8'h26, 8'h00, 16'h5EA2, 8'hBD, 2, 0, 1'b1, 8'h7A, 8'h29, 1'b0);
        vec_hl("bit7_hl", 8'h7E, 8'h00, 16'h1234, 8'h00, 1, 0, 1'b0, 8'h00, 8'h54, 1'b0);
        vec_hl("set0_hl", 8'hC6, 8'h12, 16'hBEEF, 8'h80, 0, 2, 1'b1, 8'h81, 8'h12, 1'b0);
`ifdef CB_EXEC_SLL_EN
        vec_hl("sll_hl",  8'h36, 8'h00, 16'h0F0F, 8'h01, 0, 1, 1'b1, 8'h03, 8'h04, 1'b0);
`else
        vec_hl("sll_hl",  8'h36, 8'h00, 16'h0F0F, 8'h01, 0, 1, 1'b0, 8'h01, 8'h00, 1'b1);
`endif

        // Abort an (HL) op while it waits for a read acknowledge.
        @(negedge clk);
        start = 1'b1; opcode = 8'h26; operand = 8'h00; f_in = 8'h00; hl = 16'h4321; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_in_rd", 32'(mem_rd), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_rd", 32'(mem_rd), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_state", 32'(dut.state), 0);
        reset = 1'b0;
        @(negedge clk);
        check("abort_no_done", 32'(done), 0);
        vec_reg("sla_after", 8'h27, 8'hBF, 8'h00, 8'h7E, 8'h2D, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
